// File: rtl/demux_stream.sv
// demux_stream: routes a valid/ready input stream to one of CHANNELS output
// channels, or to all of them when in_bcast is high. Each channel has a
// one-entry holding register that can drain and reload in the same cycle.
// Optional build macro DEMUX_SEL_CHECK_EN: when defined, a unicast whose
// in_sel is >= CHANNELS is accepted and dropped, and err pulses for one
// cycle. When undefined, such a word is routed to channel CHANNELS-1 and
// err is tied low.
module demux_stream #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic                      in_bcast,
   output logic [CHANNELS-1:0]       out_valid,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic                      err
);

   localparam logic [SEL_W:0] CH_CNT = (SEL_W+1)'(CHANNELS);

   logic [CHANNELS-1:0]            valid_q;
   logic [CHANNELS-1:0][WIDTH-1:0] data_q;
   logic [CHANNELS-1:0]            free;
   logic [CHANNELS-1:0]            drain;
   logic [CHANNELS-1:0]            tgt;
   logic [CHANNELS-1:0]            load;
   logic [SEL_W-1:0]               eff_sel;
   logic                           in_range;
   logic                           drop;
   logic                           accept;

   // Resolve the effective destination and whether the word is dropped
   always_comb begin
      in_range = ({1'b0, in_sel} < CH_CNT);
`ifdef DEMUX_SEL_CHECK_EN
      drop    = ~in_bcast & ~in_range;
      eff_sel = in_sel;
`else
      drop    = 1'b0;
      eff_sel = in_range ? in_sel : SEL_W'(CHANNELS - 1);
`endif
   end

   // Per-channel free/drain status, target mask and the input handshake.
   // A dropped word has an empty target mask, so the AND over untargeted
   // channels makes it ready unconditionally.
   always_comb begin
      free  = ~valid_q | out_ready;
      drain = valid_q & out_ready;
      tgt   = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         tgt[k] = in_bcast | (~drop & (eff_sel == SEL_W'(k)));
      end
      in_ready = ~rst & (&(free | ~tgt));
      accept   = in_valid & in_ready;
      load     = tgt & {CHANNELS{accept}};
   end

   // Holding registers: reload wins over drain, drain clears data to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (load[k]) begin
               valid_q[k] <= 1'b1;
               data_q[k]  <= in_data;
            end else if (drain[k]) begin
               valid_q[k] <= 1'b0;
               data_q[k]  <= '0;
            end
         end
      end
   end

   // Flatten the holding registers onto the output bus, zero when empty
   always_comb begin
      out_valid = valid_q;
      out_data  = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         out_data[k*WIDTH +: WIDTH] = valid_q[k] ? data_q[k] : '0;
      end
   end

`ifdef DEMUX_SEL_CHECK_EN
   logic err_q;

   // One-cycle error pulse after a dropped out-of-range unicast is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept & drop;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Directed testbench for demux_stream: a 4-channel instance for the main
// handshake, broadcast and reset behaviour, and a 5-channel instance for
// out-of-range select handling in either build of DEMUX_SEL_CHECK_EN.
module tb_demux_stream;

   logic        clk;
   logic        rst;

   // 4-channel, 8-bit instance
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic        in_bcast;
   logic [3:0]  out_valid;
   logic [31:0] out_data;
   logic [3:0]  out_ready;
   logic        err;

   // 5-channel, 8-bit instance
   logic        in_valid5;
   logic        in_ready5;
   logic [7:0]  in_data5;
   logic [2:0]  in_sel5;
   logic        in_bcast5;
   logic [4:0]  out_valid5;
   logic [39:0] out_data5;
   logic [4:0]  out_ready5;
   logic        err5;

   int checks = 0;
   int errors = 0;

   demux_stream #(.WIDTH(8), .CHANNELS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_bcast  (in_bcast),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .err       (err)
   );

   demux_stream #(.WIDTH(8), .CHANNELS(5)) dut5 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
      .in_data   (in_data5),
      .in_sel    (in_sel5),
      .in_bcast  (in_bcast5),
      .out_valid (out_valid5),
      .out_data  (out_data5),
      .out_ready (out_ready5),
      .err       (err5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      in_sel     = '0;
      in_bcast   = 1'b0;
      out_ready  = 4'b1111;
      in_valid5  = 1'b0;
      in_data5   = '0;
      in_sel5    = '0;
      in_bcast5  = 1'b0;
      out_ready5 = 5'b11111;

      tick();
      tick();
      check("reset_out_valid", 64'(out_valid), 64'h0);
      check("reset_out_data", 64'(out_data), 64'h0);
      check("reset_in_ready", 64'(in_ready), 64'h0);
      check("reset_err", 64'(err), 64'h0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", 64'(in_ready), 64'h1);

      // Unicast to channel 2
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
      #1;
      check("uni_in_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      check("uni_out_valid", 64'(out_valid), 64'h4);
      check("uni_out_data", 64'(out_data), 64'h00A5_0000);
      tick();
      check("uni_drained", 64'(out_valid), 64'h0);

      // Backpressure on channel 1; empty channel is ready regardless of out_ready
      out_ready = 4'b1101;
      in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
      #1;
      check("bp_empty_ready", 64'(in_ready), 64'h1);
      tick();
      check("bp_fill_valid", 64'(out_valid), 64'h2);
      in_data = 8'h22;
      #1;
      check("bp_blocked_ready", 64'(in_ready), 64'h0);
      tick();
      check("bp_held_data", 64'(out_data), 64'h0000_1100);
      check("bp_held_valid", 64'(out_valid), 64'h2);
      out_ready = 4'b1111;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      check("bp_reload_valid", 64'(out_valid), 64'h2);
      check("bp_reload_data", 64'(out_data), 64'h0000_2200);
      tick();
      check("bp_drained", 64'(out_valid), 64'h0);

      // Broadcast blocked by full channel 3, then released
      out_ready = 4'b0111;
      in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h77;
      tick();
      check("bc_fill3", 64'(out_data), 64'h7700_0000);
      in_bcast = 1'b1; in_sel = 2'd0; in_data = 8'h3C;
      #1;
      check("bc_blocked_ready", 64'(in_ready), 64'h0);
      tick();
      check("bc_unchanged_valid", 64'(out_valid), 64'h8);
      check("bc_unchanged_data", 64'(out_data), 64'h7700_0000);
      out_ready = 4'b1111;
      #1;
      check("bc_release_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0; in_bcast = 1'b0;
      check("bc_all_valid", 64'(out_valid), 64'hF);
      check("bc_all_data", 64'(out_data), 64'h3C3C_3C3C);
      tick();
      check("bc_drained", 64'(out_valid), 64'h0);

      // Channel 2 held while channel 0 streams one word per cycle
      out_ready = 4'b1011;
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h5A;
      tick();
      in_sel = 2'd0;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'h40 + 8'(i);
         tick();
         check("stream_valid", 64'(out_valid), 64'h5);
         check("stream_data", 64'(out_data), {32'h0, 8'h00, 8'h5A, 8'h00, 8'h40 + 8'(i)});
      end
      in_valid = 1'b0;
      out_ready = 4'b1111;
      tick();
      check("stream_drained", 64'(out_valid), 64'h0);
      check("err_pow2", 64'(err), 64'h0);

      // Reset mid-operation with channels 0 and 3 full
      out_ready = 4'b0000;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h0F;
      tick();
      in_sel = 2'd3; in_data = 8'hF0;
      tick();
      check("rst_pre_valid", 64'(out_valid), 64'h9);
      check("rst_pre_data", 64'(out_data), 64'hF000_000F);
      in_sel = 2'd1; in_data = 8'hEE;
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_valid", 64'(out_valid), 64'h0);
      check("rst_async_data", 64'(out_data), 64'h0);
      check("rst_async_ready", 64'(in_ready), 64'h0);
      tick();
      rst = 1'b0; in_valid = 1'b0;
      tick();
      check("rst_inflight_gone", 64'(out_valid), 64'h0);
      out_ready = 4'b1111;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h99;
      tick();
      in_valid = 1'b0;
      check("rst_after_valid", 64'(out_valid), 64'h1);
      check("rst_after_data", 64'(out_data), 64'h0000_0099);

      // Out-of-range select on the 5-channel instance
      in_valid5 = 1'b1; in_sel5 = 3'd6; in_data5 = 8'hE7;
      #1;
      check("oor_ready", 64'(in_ready5), 64'h1);
      tick();
      in_valid5 = 1'b0;
`ifdef DEMUX_SEL_CHECK_EN
      check("oor_err_pulse", 64'(err5), 64'h1);
      check("oor_valid", 64'(out_valid5), 64'h0);
      check("oor_data", 64'(out_data5), 64'h0);
`else
      check("oor_err_pulse", 64'(err5), 64'h0);
      check("oor_valid", 64'(out_valid5), 64'h10);
      check("oor_data", 64'(out_data5), 64'hE7_0000_0000);
`endif
      tick();
      check("oor_err_end", 64'(err5), 64'h0);
      check("oor_drained", 64'(out_valid5), 64'h0);

      // In-range select 4 on the 5-channel instance
      in_valid5 = 1'b1; in_sel5 = 3'd4; in_data5 = 8'h4D;
      tick();
      in_valid5 = 1'b0;
      check("ch4_valid", 64'(out_valid5), 64'h10);
      check("ch4_data", 64'(out_data5), 64'h4D_0000_0000);
      check("ch4_err", 64'(err5), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
